// File: rtl/regfile_writeback_unit_pkg.sv
// Shared widths and the queued write-back entry type for the register-file writer.
package regfile_writeback_unit_pkg;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned REG_N    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              live;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_ALU   = 2'd1,
    SEL_QUEUE = 2'd2
  } wb_sel_e;
endpackage

// File: rtl/regfile_writeback_unit_kill_queue.sv
// Circular FIFO of pending long-latency writes; entries can be killed by destination address.
module wb_kill_queue
  import regfile_writeback_unit_pkg::*;
#(
  parameter int unsigned Q_DEPTH = 4,
  localparam int unsigned PTR_W  = $clog2(Q_DEPTH),
  localparam int unsigned CNT_W  = $clog2(Q_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_kill,
  input  logic [ADDR_W-1:0] i_kill_addr,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [DATA_W-1:0] o_head_data,
  output logic              o_head_live,
  output logic [CNT_W-1:0]  o_count,
  output logic [REG_N-1:0]  o_live_mask
);
  wb_entry_t        r_mem [Q_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_push_live;

  // A same-cycle kill to the pushed address makes the new entry dead on arrival.
  assign w_push_live = !(i_kill && (i_kill_addr == i_push_addr));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < Q_DEPTH; i++) r_mem[i].live <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < Q_DEPTH; i++) begin
        if (i_kill && (r_mem[i].addr == i_kill_addr)) r_mem[PTR_W'(i)].live <= 1'b0;
      end
      if (i_pop) begin
        r_mem[r_head].live <= 1'b0;
        r_head             <= r_head + 1'b1;
      end
      if (i_push) begin
        r_mem[r_tail] <= '{addr: i_push_addr, data: i_push_data, live: w_push_live};
        r_tail        <= r_tail + 1'b1;
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  // Freed slots have live cleared, so OR-ing over every slot gives the outstanding set.
  always_comb begin
    o_live_mask = '0;
    for (int unsigned i = 0; i < Q_DEPTH; i++) begin
      if (r_mem[i].live) o_live_mask[r_mem[i].addr] = 1'b1;
    end
  end

  assign o_head_addr = r_mem[r_head].addr;
  assign o_head_data = r_mem[r_head].data;
  assign o_head_live = r_mem[r_head].live;
  assign o_count     = r_count;
endmodule

// File: rtl/regfile_writeback_unit.sv
// Register-file write port arbiter: ALU results take priority over queued long-latency results.
module regfile_writeback_unit
  import regfile_writeback_unit_pkg::*;
#(
  parameter int unsigned Q_DEPTH = 4,
  localparam int unsigned CNT_W  = $clog2(Q_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] addressWrite,
  output logic [DATA_W-1:0] dataWrite,
  output logic [REG_N-1:0]  pending_mask,
  output logic [CNT_W-1:0]  q_count
);
  logic              w_alu_wr;
  logic              w_push;
  logic              w_pop;
  wb_sel_e           w_sel;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_live;
  logic [CNT_W-1:0]  w_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  assign w_alu_wr  = alu_valid && (alu_addr != ZERO_REG);
  assign mem_ready = !rst && (w_count < CNT_W'(Q_DEPTH));
  assign w_push    = mem_valid && mem_ready && (mem_addr != ZERO_REG);
  assign w_pop     = (w_sel == SEL_QUEUE);

  always_comb begin
    w_sel = SEL_NONE;
    if (w_alu_wr)           w_sel = SEL_ALU;
    else if (w_count != '0) w_sel = SEL_QUEUE;
  end

  wb_kill_queue #(.Q_DEPTH(Q_DEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_addr (mem_addr),
    .i_push_data (mem_data),
    .i_pop       (w_pop),
    .i_kill      (w_alu_wr),
    .i_kill_addr (alu_addr),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_head_live (w_head_live),
    .o_count     (w_count),
    .o_live_mask (pending_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= 1'b0;
      case (w_sel)
        SEL_ALU: begin
          r_we   <= 1'b1;
          r_addr <= alu_addr;
          r_data <= alu_data;
        end
        SEL_QUEUE: begin
          if (w_head_live) begin
            r_we   <= 1'b1;
            r_addr <= w_head_addr;
            r_data <= w_head_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign writeEnable  = r_we;
  assign addressWrite = r_addr;
  assign dataWrite    = r_data;
  assign q_count      = w_count;
endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Scoreboard bench: a queue-level reference model predicts register writes; a monitor checks them.
module tb_regfile_writeback_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        writeEnable;
  logic [4:0]  addressWrite;
  logic [31:0] dataWrite;
  logic [31:0] pending_mask;
  logic [2:0]  q_count;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          live;
  } m_ent_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  m_ent_t mq[$];
  wr_t    expq[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  regfile_writeback_unit #(.Q_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .writeEnable  (writeEnable),
    .addressWrite (addressWrite),
    .dataWrite    (dataWrite),
    .pending_mask (pending_mask),
    .q_count      (q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) if (mq[i].live) m[mq[i].addr] = 1'b1;
    return m;
  endfunction

  // One clock cycle: check registered state, drive inputs, then advance the reference model.
  task automatic step(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md);
    bit rdy, alu_wr;
    m_ent_t e;
    @(negedge clk);
    chk("q_count", 64'(q_count), 64'(mq.size()));
    chk("pending_mask", 64'(pending_mask), 64'(model_mask()));
    rst = r; alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    #1;
    rdy = !r && (mq.size() < 4);
    chk("mem_ready", 64'(mem_ready), 64'(rdy));
    if (r) begin
      mq.delete();
    end else begin
      alu_wr = av && (aa != 5'd0);
      if (alu_wr) begin
        foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 1'b0;
        expq.push_back('{addr: aa, data: ad});
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        if (e.live) expq.push_back('{addr: e.addr, data: e.data});
      end
      if (mv && rdy && (ma != 5'd0))
        mq.push_back('{addr: ma, data: md, live: !(alu_wr && (ma == aa))});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: every presented write must match the oldest predicted one; idle cycles hold the port.
  initial begin
    logic        prev_rst;
    logic [4:0]  la;
    logic [31:0] ld;
    wr_t         w;
    la = '0;
    ld = '0;
    forever begin
      @(posedge clk);
      prev_rst = rst;
      @(negedge clk);
      if (prev_rst) begin
        chk("rst_writeEnable", 64'(writeEnable), 64'(0));
        chk("rst_addressWrite", 64'(addressWrite), 64'(0));
        chk("rst_dataWrite", 64'(dataWrite), 64'(0));
        la = '0;
        ld = '0;
      end else if (writeEnable === 1'b1) begin
        if (expq.size() == 0) begin
          chk("unexpected_write", 64'(addressWrite), 64'hFFFF_FFFF);
        end else begin
          w = expq.pop_front();
          chk("write_addr", 64'(addressWrite), 64'(w.addr));
          chk("write_data", 64'(dataWrite), 64'(w.data));
        end
        la = addressWrite;
        ld = dataWrite;
      end else begin
        chk("idle_writeEnable", 64'(writeEnable), 64'(0));
        chk("hold_addr", 64'(addressWrite), 64'(la));
        chk("hold_data", 64'(dataWrite), 64'(ld));
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    // ALU write to r3
    step(1'b0, 1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 32'd0);
    idle(2);
    // single queued write to r7
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
    idle(3);
    // fill the queue while the ALU starves it
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 5'd1, 32'(i), 1'b1, 5'(8 + i), 32'h100 + 32'(i));
    idle(6);
    // queued r5 superseded by a younger ALU write
    step(1'b0, 1'b1, 5'd2, 32'h1, 1'b1, 5'd5, 32'h22);
    step(1'b0, 1'b1, 5'd5, 32'h33, 1'b0, 5'd0, 32'd0);
    idle(3);
    // same-cycle push and ALU kill to the same register
    step(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h98);
    idle(2);
    // r0 traffic on both sources while a queued entry drains
    step(1'b0, 1'b1, 5'd4, 32'h4, 1'b1, 5'd6, 32'h66);
    step(1'b0, 1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE);
    idle(2);
    // reset with three live entries outstanding
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 5'd2, 32'(i), 1'b1, 5'(20 + i), 32'h200 + 32'(i));
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(4);
    for (int i = 0; i < 600; i++)
      step(($urandom_range(63) == 0), ($urandom_range(99) < 55), 5'($urandom_range(7)), $urandom,
           ($urandom_range(99) < 65), 5'($urandom_range(7)), $urandom);
    idle(10);
    @(negedge clk);
    chk("scoreboard_drained", 64'(expq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
